// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction quadrant encoding, aligner
// defaults and the parcel classification helper.
package cpu_pkg;

    localparam logic [1:0] QUAD3               = 2'b11;
    localparam bit         C_EXTENSION_DEFAULT = 1'b1;
    localparam int         QDEPTH_DEFAULT      = 4;

    typedef enum logic {
        PARCEL_16 = 1'b0,
        PARCEL_32 = 1'b1
    } parcel_e;

    // Without the compressed extension every parcel starts a 32-bit instruction.
    function automatic parcel_e classify(input logic [15:0] hw, input bit cext);
        return (!cext || (hw[1:0] == QUAD3)) ? PARCEL_32 : PARCEL_16;
    endfunction

endpackage

// File: rtl/hw_fifo.sv
// Halfword queue with two write lanes and two read lanes; pushes and pops of
// 0..2 halfwords per cycle, combinational head read, flush clears pointers.
module hw_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = QDEPTH_DEFAULT,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            flush,
    input  logic [1:0]      push_n,
    input  logic [1:0][15:0] wr_data,
    input  logic [1:0]      pop_n,
    output logic [1:0][15:0] rd_data,
    output logic [CW-1:0]   count
);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] wr_addr [2];
    logic [PW-1:0] rd_addr [2];
    logic [1:0]    wr_en;

    // Lane gi sits gi entries past the pointer; power-of-two depth wraps freely.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign wr_addr[gi] = wr_ptr_reg + PW'(gi);
            assign rd_addr[gi] = rd_ptr_reg + PW'(gi);
            assign wr_en[gi]   = (push_n > 2'(gi));
            assign rd_data[gi] = mem[rd_addr[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
                mem[wr_addr[i]] <= wr_data[i];
            end
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PW'(push_n);
        rd_ptr_next = rd_ptr_reg + PW'(pop_n);
        count_next  = count_reg + CW'(push_n) - CW'(pop_n);
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/inst_align.sv
// Instruction aligner: turns word-aligned fetch words into 16/32-bit
// instructions with their PCs, handling straddles and halfword redirects.
module inst_align
    import cpu_pkg::*;
#(
    parameter bit C_EXTENSION = C_EXTENSION_DEFAULT,
    parameter int QDEPTH      = QDEPTH_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_word,
    output logic        o_fetch_ready,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_compressed
);

    localparam int CW = $clog2(QDEPTH + 1);
    // A 32-bit-only core cannot land on a halfword boundary, so bit 1 is dropped too.
    localparam logic [31:0] FLUSH_MASK = C_EXTENSION ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

    logic [31:0]      pc_reg, pc_next;
    logic             skip_reg, skip_next;
    logic [CW-1:0]    fifo_count;
    logic [1:0][15:0] rd_data;
    logic [1:0][15:0] wr_data;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic [31:0]      flush_target;
    logic             head_is_c;
    logic             fetch_ready;
    logic             inst_valid;
    logic             accept;
    logic             fire;

    hw_fifo #(
        .DEPTH (QDEPTH)
    ) u_hw_fifo (
        .clk     (i_clk),
        .srst    (i_rst),
        .flush   (i_flush),
        .push_n  (push_n),
        .wr_data (wr_data),
        .pop_n   (pop_n),
        .rd_data (rd_data),
        .count   (fifo_count)
    );

    assign flush_target = i_flush_pc & FLUSH_MASK;
    assign head_is_c    = (classify(rd_data[0], C_EXTENSION) == PARCEL_16);
    assign fetch_ready  = (fifo_count <= CW'(QDEPTH - 2));
    assign inst_valid   = head_is_c ? (fifo_count >= CW'(1)) : (fifo_count >= CW'(2));
    assign accept       = i_fetch_valid && fetch_ready && !i_flush;
    assign fire         = inst_valid && i_inst_ready && !i_flush;

    // After a redirect to an odd halfword the lower half of the first word is dead.
    always_comb begin
        push_n     = 2'd0;
        wr_data[0] = i_fetch_word[15:0];
        wr_data[1] = i_fetch_word[31:16];
        if (accept) begin
            if (skip_reg) begin
                push_n     = 2'd1;
                wr_data[0] = i_fetch_word[31:16];
            end else begin
                push_n     = 2'd2;
            end
        end
    end

    always_comb begin
        pop_n = 2'd0;
        if (fire) begin
            pop_n = head_is_c ? 2'd1 : 2'd2;
        end
    end

    always_comb begin
        pc_next   = pc_reg;
        skip_next = skip_reg;
        if (i_flush) begin
            pc_next   = flush_target;
            skip_next = flush_target[1];
        end else begin
            if (fire) begin
                pc_next = pc_reg + (head_is_c ? 32'd2 : 32'd4);
            end
            if (accept) begin
                skip_next = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_reg   <= 32'h0000_0000;
            skip_reg <= 1'b0;
        end else begin
            pc_reg   <= pc_next;
            skip_reg <= skip_next;
        end
    end

    assign o_fetch_ready = fetch_ready;
    assign o_inst_valid  = inst_valid;
    assign o_inst        = head_is_c ? {16'h0000, rd_data[0]} : {rd_data[1], rd_data[0]};
    assign o_inst_pc     = pc_reg;
    assign o_compressed  = head_is_c;

endmodule

// File: tb/tb_inst_align.sv
// Directed bench for inst_align: expected instructions are queued as stimulus
// is driven and compared whenever the aligner hands one to decode.
module tb_inst_align;

    localparam int QDEPTH = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    logic        clk;
    logic        i_rst;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic        i_fetch_valid;
    logic [31:0] i_fetch_word;
    logic        o_fetch_ready;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_compressed;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    inst_align #(
        .C_EXTENSION (1'b1),
        .QDEPTH      (QDEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_flush       (i_flush),
        .i_flush_pc    (i_flush_pc),
        .i_fetch_valid (i_fetch_valid),
        .i_fetch_word  (i_fetch_word),
        .o_fetch_ready (o_fetch_ready),
        .o_inst_valid  (o_inst_valid),
        .i_inst_ready  (i_inst_ready),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .o_compressed  (o_compressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_inst(input logic [31:0] inst, input logic [31:0] pc, input logic c);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        e.c    = c;
        sb.push_back(e);
    endtask

    // One clock: compare any handed-off instruction at the falling edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!i_rst && !i_flush && o_inst_valid && i_inst_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_inst", o_inst, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("inst", o_inst, e.inst);
                chk("inst_pc", o_inst_pc, e.pc);
                chk("compressed", 32'(o_compressed), 32'(e.c));
                $display("out inst=%h pc=%h c=%0b", o_inst, o_inst_pc, o_compressed);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        i_flush    = 1'b1;
        i_flush_pc = pc;
        tick();
        i_flush    = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        i_fetch_valid = 1'b1;
        i_fetch_word  = w;
        tick();
        i_fetch_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            tick();
        end
        chk({tag, "_left"}, 32'(sb.size()), 32'd0);
        chk({tag, "_valid_after"}, 32'(o_inst_valid), 32'd0);
    endtask

    initial begin
        int          mcount;
        logic [31:0] pcm;
        logic [7:0]  kb;

        n_cmp         = 0;
        n_err         = 0;
        i_rst         = 1'b1;
        i_flush       = 1'b0;
        i_flush_pc    = 32'h0;
        i_fetch_valid = 1'b0;
        i_fetch_word  = 32'h0;
        i_inst_ready  = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        chk("rst_valid", 32'(o_inst_valid), 32'd0);
        chk("rst_fetch_ready", 32'(o_fetch_ready), 32'd1);
        chk("rst_pc", o_inst_pc, 32'h0);

        // Single aligned 32-bit instruction.
        i_inst_ready = 1'b1;
        expect_inst(32'h00A0_0093, 32'h0, 1'b0);
        push_word(32'h00A0_0093);
        chk("t1_valid_next", 32'(o_inst_valid), 32'd1);
        tick();
        chk("t1_valid_after_pop", 32'(o_inst_valid), 32'd0);
        chk("t1_pc_after_pop", o_inst_pc, 32'h4);

        // Two compressed parcels in one word.
        do_flush(32'h0);
        expect_inst(32'h0000_0505, 32'h0, 1'b1);
        expect_inst(32'h0000_4585, 32'h2, 1'b1);
        push_word(32'h4585_0505);
        drain("t2");

        // 32-bit instruction straddling two words.
        do_flush(32'h0);
        expect_inst(32'h0000_0505, 32'h0, 1'b1);
        expect_inst(32'h00A0_0093, 32'h2, 1'b0);
        expect_inst(32'h0000_0000, 32'h6, 1'b1);
        push_word(32'h0093_0505);
        tick();
        chk("t3_straddle_wait", 32'(o_inst_valid), 32'd0);
        tick();
        chk("t3_straddle_wait2", 32'(o_inst_valid), 32'd0);
        chk("t3_pc_wait", o_inst_pc, 32'h2);
        push_word(32'h0000_00A0);
        drain("t3");

        // Redirect to an odd halfword skips the lower parcel.
        do_flush(32'h0000_0102);
        chk("t4_flush_pc", o_inst_pc, 32'h0000_0102);
        expect_inst(32'h0000_4585, 32'h0000_0102, 1'b1);
        push_word(32'h4585_0505);
        drain("t4");
        chk("t4_pc_end", o_inst_pc, 32'h0000_0104);

        // Decode stalled while fetch keeps pushing: backpressure and no loss.
        do_flush(32'h0);
        i_inst_ready = 1'b0;
        mcount       = 0;
        pcm          = 32'h0;
        for (int k = 0; k < 6; k++) begin
            kb            = 8'(k);
            i_fetch_valid = 1'b1;
            i_fetch_word  = {kb, 8'h08, kb, 8'h04};
            @(negedge clk);
            chk("t5_fetch_ready", 32'(o_fetch_ready), 32'(mcount <= QDEPTH - 2));
            if (k > 0) begin
                chk("t5_hold_valid", 32'(o_inst_valid), 32'd1);
                chk("t5_hold_inst", o_inst, 32'h0000_0004);
                chk("t5_hold_pc", o_inst_pc, 32'h0);
            end
            if (o_fetch_ready) begin
                expect_inst({16'h0000, kb, 8'h04}, pcm, 1'b1);
                expect_inst({16'h0000, kb, 8'h08}, pcm + 32'd2, 1'b1);
                pcm    = pcm + 32'd4;
                mcount = mcount + 2;
            end
            @(posedge clk);
            #1;
        end
        i_fetch_valid = 1'b0;
        i_inst_ready  = 1'b1;
        drain("t5");
        chk("t5_pc_end", o_inst_pc, pcm);

        // Flush coinciding with an accepted push wins.
        i_inst_ready = 1'b0;
        push_word(32'h4585_0505);
        chk("t6_prefill_valid", 32'(o_inst_valid), 32'd1);
        i_fetch_valid = 1'b1;
        i_fetch_word  = 32'h1111_1111;
        do_flush(32'h0000_0200);
        i_fetch_valid = 1'b0;
        chk("t6_empty", 32'(o_inst_valid), 32'd0);
        chk("t6_pc", o_inst_pc, 32'h0000_0200);
        chk("t6_fetch_ready", 32'(o_fetch_ready), 32'd1);
        i_inst_ready = 1'b1;
        expect_inst(32'h0000_0505, 32'h0000_0200, 1'b1);
        expect_inst(32'h0000_4585, 32'h0000_0202, 1'b1);
        push_word(32'h4585_0505);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_align.md
INST_ALIGN -- requirements
Module: inst_align

Interface
REQ-001 Parameter C_EXTENSION, default 1: 1 accepts 16-bit compressed parcels; 0 treats every instruction as 32-bit.
REQ-002 Parameter QDEPTH, default 4: halfword queue depth, a power of 2 and at least 4.
REQ-003 i_clk  input  1  sole clock; every register updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_flush  input  1  redirect: discard queue contents and restart at i_flush_pc.
REQ-006 i_flush_pc  input  32  redirect target, halfword aligned (bit 0 ignored).
REQ-007 i_fetch_valid  input  1  i_fetch_word holds a valid word-aligned fetch word.
REQ-008 i_fetch_word  input  32  fetched word; bits [15:0] are the lower halfword.
REQ-009 o_fetch_ready  output  1  aligner accepts the fetch word this cycle.
REQ-010 o_inst_valid  output  1  o_inst, o_inst_pc and o_compressed are valid.
REQ-011 i_inst_ready  input  1  decode stage consumes the instruction this cycle.
REQ-012 o_inst  output  32  aligned instruction; bits [31:16] are zero when compressed.
REQ-013 o_inst_pc  output  32  PC of o_inst.
REQ-014 o_compressed  output  1  o_inst is a 16-bit parcel.

Function
REQ-015 A fetch word is accepted when i_fetch_valid && o_fetch_ready && !i_flush; it pushes 2 halfwords, lower first, or only the upper halfword when the skip flag is set.
REQ-016 o_fetch_ready is 1 when free entries ≥ 2, computed from the registered count only (no same-cycle pop lookahead).
REQ-017 Head parcel classification: 32-bit when head[1:0] == 2'b11 or C_EXTENSION == 0; otherwise compressed.
REQ-018 o_inst_valid = (count ≥ 1 && compressed) || (count ≥ 2 && 32-bit); the output is combinational from the queue head, so a word accepted in cycle N is presentable in cycle N+1.
REQ-019 On o_inst_valid && i_inst_ready: pop 1 halfword and add 2 to o_inst_pc when compressed; pop 2 halfwords and add 4 when 32-bit; wrap modulo 2^32.
REQ-020 Push and pop in the same cycle are both performed; count updates by the net amount.
REQ-021 A 32-bit instruction straddling two fetch words waits with o_inst_valid=0 until the second word's lower halfword is queued.
REQ-022 On i_flush: count=0, read/write pointers=0, o_inst_pc=i_flush_pc with bit0 cleared, skip flag=i_flush_pc[1]; i_flush has priority over any same-cycle push or pop, and the fetch input is dropped.
REQ-023 The skip flag clears on the first accepted fetch word after the flush.
REQ-024 With C_EXTENSION=0, i_flush_pc[1] is ignored (treated as 0) and the skip flag never sets.
REQ-025 Queue pointers wrap modulo QDEPTH; the count is clog2(QDEPTH+1) bits wide.
REQ-026 o_inst, o_inst_pc and o_compressed remain stable while o_inst_valid && !i_inst_ready.

Reset
REQ-027 On i_rst: count=0, pointers=0, skip flag=0, o_inst_pc=32'h0000_0000, o_inst_valid=0, o_fetch_ready=1.
REQ-028 i_rst has priority over i_flush and all handshakes; a transfer in flight during reset is discarded.
REQ-029 Queue data storage is not reset; o_inst is don't-care while o_inst_valid=0.

Structure
REQ-030 Shared package cpu_pkg holds the quadrant constant QUAD3=2'b11 and the default values of C_EXTENSION and QDEPTH.
REQ-031 Halfword storage is a sub-module hw_fifo (parametrised depth, 2-in/2-out halfword ports, flush); alignment, PC tracking and the skip flag stay in inst_align.

Verification
REQ-032 Reset, then 32'h00A00093 at PC 0 -> next cycle o_inst=32'h00A00093, o_compressed=0, o_inst_pc=0; after pop, o_inst_valid=0.
REQ-033 Word 32'h4585_0505 -> two compressed outputs: 32'h0000_0505 at PC 0, then 32'h0000_4585 at PC 2.
REQ-034 Words 32'h0093_0505 then 32'h0000_00A0 -> compressed 0x0505 at PC 0, then 32-bit 32'h00A0_0093 at PC 2 (straddle), with valid held low until the second word arrives.
REQ-035 i_flush_pc=32'h0000_0102, then word 32'h4585_0505 -> only 32'h0000_4585 is output, at PC 0x102.
REQ-036 i_inst_ready held 0 with words pushed continuously -> o_fetch_ready drops when count > QDEPTH-2 and no halfword is lost or duplicated.
REQ-037 i_flush and an accepted push in the same cycle -> queue empty the next cycle and o_inst_pc equals the flush target.
